// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: register enables, flush/bubble
// decode, memory-timeout detection and saturating event counters.
module pipeline_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_req,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             clr_cnt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic [1:0]       state,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam int unsigned TMR_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             stall_inc, flush_inc, wait_inc;
  logic             stall_masked;

  assign state        = state_q;
  assign stall_masked = (state_q == LU_STALL) || (state_q == FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Priority decode: mem_busy > branch_taken > unmasked stall_req > run.
  always_comb begin
    state_d      = RUN;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    wait_inc     = 1'b0;
    if (mem_busy) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      wait_inc     = 1'b1;
      state_d      = MEM_WAIT;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_inc  = 1'b1;
      state_d    = FLUSH;
    end else if (stall_req && !stall_masked) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      stall_inc  = 1'b1;
      state_d    = LU_STALL;
    end
    // Hold the pipeline frozen and filled with NOPs while in reset.
    if (!rst_n) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      wait_inc     = 1'b0;
      state_d      = RUN;
    end
  end

  // Consecutive-busy timer, saturating at the timeout value.
  always_comb begin
    timer_d = '0;
    if (mem_busy) begin
      if (timer_q == TMR_W'(MEM_TIMEOUT)) timer_d = timer_q;
      else                                timer_d = timer_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      mem_err <= 1'b0;
    end else begin
      timer_q <= timer_d;
      if (mem_busy && (timer_d == TMR_W'(MEM_TIMEOUT))) mem_err <= 1'b1;
    end
  end

  // Event counters: clear wins over increment, saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      if (wait_inc  && (wait_cnt  != '1)) wait_cnt  <= wait_cnt  + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a default-width instance and a 4-bit
// counter instance share the same stimulus.
module tb_pipeline_ctrl;

  localparam logic [6:0] RUN_C   = 7'b1111_000;
  localparam logic [6:0] STALL_C = 7'b0011_010;
  localparam logic [6:0] FLUSH_C = 7'b1111_110;
  localparam logic [6:0] BUSY_C  = 7'b0000_001;
  localparam logic [6:0] RST_C   = 7'b0000_111;

  logic clk, rst_n, stall_req, branch_taken, mem_busy, clr_cnt;

  logic        a_pc, a_ifid, a_idex, a_exmem, a_iff, a_idf, a_bub, a_err;
  logic [1:0]  a_state;
  logic [15:0] a_stall, a_flush, a_wait;
  logic        b_pc, b_ifid, b_idex, b_exmem, b_iff, b_idf, b_bub, b_err;
  logic [1:0]  b_state;
  logic [3:0]  b_stall, b_flush, b_wait;
  logic [6:0]  a_ctrl, b_ctrl;

  assign a_ctrl = {a_pc, a_ifid, a_idex, a_exmem, a_iff, a_idf, a_bub};
  assign b_ctrl = {b_pc, b_ifid, b_idex, b_exmem, b_iff, b_idf, b_bub};

  int errors = 0;
  int checks = 0;

  pipeline_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .clr_cnt(clr_cnt),
    .pc_en(a_pc), .ifid_en(a_ifid), .idex_en(a_idex), .exmem_en(a_exmem),
    .ifid_flush(a_iff), .idex_flush(a_idf), .memwb_bubble(a_bub),
    .state(a_state), .mem_err(a_err),
    .stall_cnt(a_stall), .flush_cnt(a_flush), .wait_cnt(a_wait)
  );

  pipeline_ctrl #(.CNT_W(4), .MEM_TIMEOUT(255)) u_sat (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .clr_cnt(clr_cnt),
    .pc_en(b_pc), .ifid_en(b_ifid), .idex_en(b_idex), .exmem_en(b_exmem),
    .ifid_flush(b_iff), .idex_flush(b_idf), .memwb_bubble(b_bub),
    .state(b_state), .mem_err(b_err),
    .stall_cnt(b_stall), .flush_cnt(b_flush), .wait_cnt(b_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       s;
    logic       b;
    logic       m;
    logic [6:0] ctrl;
    logic [1:0] st;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic b, input logic m,
                              input logic [6:0] ctrl, input logic [1:0] st);
    vec_t v;
    v.s = s; v.b = b; v.m = m; v.ctrl = ctrl; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic s, input logic b, input logic m, input logic c);
    stall_req = s; branch_taken = b; mem_busy = m; clr_cnt = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int st, input int fl, input int wt,
                         input int bst, input int bfl, input int bwt);
    chk({tag, " a_stall_cnt"}, 32'(a_stall), 32'(st));
    chk({tag, " a_flush_cnt"}, 32'(a_flush), 32'(fl));
    chk({tag, " a_wait_cnt"},  32'(a_wait),  32'(wt));
    chk({tag, " b_stall_cnt"}, 32'(b_stall), 32'(bst));
    chk({tag, " b_flush_cnt"}, 32'(b_flush), 32'(bfl));
    chk({tag, " b_wait_cnt"},  32'(b_wait),  32'(bwt));
  endtask

  vec_t vecs[20];

  initial begin
    // Each row: inputs for one cycle, expected comb controls and current state.
    vecs[0]  = mk(0, 0, 0, RUN_C,   2'd0);
    vecs[1]  = mk(1, 0, 0, STALL_C, 2'd0);
    vecs[2]  = mk(1, 0, 0, RUN_C,   2'd1);
    vecs[3]  = mk(1, 0, 0, STALL_C, 2'd0);
    vecs[4]  = mk(0, 0, 0, RUN_C,   2'd1);
    vecs[5]  = mk(1, 1, 0, FLUSH_C, 2'd0);
    vecs[6]  = mk(1, 0, 0, RUN_C,   2'd2);
    vecs[7]  = mk(0, 0, 0, RUN_C,   2'd0);
    vecs[8]  = mk(0, 1, 1, BUSY_C,  2'd0);
    vecs[9]  = mk(0, 1, 1, BUSY_C,  2'd3);
    vecs[10] = mk(0, 1, 1, BUSY_C,  2'd3);
    vecs[11] = mk(0, 1, 1, BUSY_C,  2'd3);
    vecs[12] = mk(0, 1, 0, FLUSH_C, 2'd3);
    vecs[13] = mk(0, 0, 0, RUN_C,   2'd2);
    vecs[14] = mk(1, 0, 1, BUSY_C,  2'd0);
    vecs[15] = mk(1, 0, 0, STALL_C, 2'd3);
    vecs[16] = mk(0, 0, 0, RUN_C,   2'd1);
    vecs[17] = mk(1, 0, 0, STALL_C, 2'd0);
    vecs[18] = mk(0, 0, 1, BUSY_C,  2'd1);
    vecs[19] = mk(0, 0, 0, RUN_C,   2'd3);

    rst_n = 1'b0;
    apply(0, 0, 0, 0);
    #1;
    chk("reset ctrl", 32'(a_ctrl), 32'(RST_C));
    chk("reset ctrl b", 32'(b_ctrl), 32'(RST_C));
    chk("reset state", 32'(a_state), 32'd0);
    chk("reset mem_err", 32'(a_err), 32'd0);
    chk_cnt("reset", 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i].s, vecs[i].b, vecs[i].m, 1'b0);
      chk($sformatf("vec%0d ctrl", i), 32'(a_ctrl), 32'(vecs[i].ctrl));
      chk($sformatf("vec%0d ctrl b", i), 32'(b_ctrl), 32'(vecs[i].ctrl));
      chk($sformatf("vec%0d state", i), 32'(a_state), 32'(vecs[i].st));
      tick();
      if (i == 3) chk("two stalls stall_cnt", 32'(a_stall), 32'd2);
      if (i == 7) chk("branch flush_cnt", 32'(a_flush), 32'd1);
    end
    chk_cnt("table", 4, 2, 6, 4, 2, 6);
    chk("table mem_err", 32'(a_err), 32'd0);

    // Clear with nothing pending.
    apply(0, 0, 0, 1);
    tick();
    chk_cnt("clear", 0, 0, 0, 0, 0, 0);

    // Reset mid-stall aborts immediately; first cycle after release decodes as RUN.
    apply(1, 0, 0, 0);
    tick();
    chk("pre-reset state", 32'(a_state), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset state", 32'(a_state), 32'd0);
    chk("async reset ctrl", 32'(a_ctrl), 32'(RST_C));
    tick();
    rst_n = 1'b1;
    apply(1, 0, 0, 0);
    chk("post-reset stall ctrl", 32'(a_ctrl), 32'(STALL_C));
    tick();
    chk_cnt("post-reset", 1, 0, 0, 1, 0, 0);

    // Saturation: continuous stall_req gives one bubble every other cycle.
    apply(0, 0, 0, 1);
    tick();
    for (int i = 0; i < 40; i++) begin
      apply(1, 0, 0, 0);
      tick();
    end
    chk_cnt("saturate", 20, 0, 0, 15, 0, 0);
    chk("saturate state", 32'(a_state), 32'd0);
    apply(1, 0, 0, 1);
    chk("clr+stall ctrl", 32'(a_ctrl), 32'(STALL_C));
    tick();
    chk_cnt("clr wins", 0, 0, 0, 0, 0, 0);
    chk("clr+stall state", 32'(a_state), 32'd1);

    // A single idle cycle restarts the wait timer.
    apply(0, 0, 0, 0);
    tick();
    for (int i = 0; i < 200; i++) begin apply(0, 0, 1, 0); tick(); end
    apply(0, 0, 0, 0);
    tick();
    for (int i = 0; i < 200; i++) begin apply(0, 0, 1, 0); tick(); end
    chk("non-consecutive mem_err", 32'(a_err), 32'd0);
    apply(0, 0, 0, 1);
    tick();

    // Timeout after 255 consecutive busy edges, sticky afterwards.
    for (int i = 1; i <= 300; i++) begin
      apply(0, 0, 1, 0);
      tick();
      if (i == 254) chk("mem_err at 254", 32'(a_err), 32'd0);
      if (i == 255) chk("mem_err at 255", 32'(a_err), 32'd1);
    end
    chk("timeout state", 32'(a_state), 32'd3);
    chk_cnt("timeout", 0, 0, 300, 0, 0, 15);
    apply(0, 0, 0, 1);
    chk("busy drop ctrl", 32'(a_ctrl), 32'(RUN_C));
    tick();
    chk("mem_err sticky", 32'(a_err), 32'd1);
    chk("mem_err sticky b", 32'(b_err), 32'd1);
    chk("clr keeps mem_err", 32'(a_err), 32'd1);
    chk_cnt("clr after timeout", 0, 0, 0, 0, 0, 0);

    // Reset mid-wait clears state and mem_err.
    apply(0, 0, 1, 0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset mid-wait state", 32'(a_state), 32'd0);
    chk("reset mid-wait mem_err", 32'(a_err), 32'd0);
    tick();
    rst_n = 1'b1;
    apply(0, 0, 0, 0);
    chk("final run ctrl", 32'(a_ctrl), 32'(RUN_C));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
